// File: rtl/pwm_pkg.sv
// Shared constants and types for the servo PWM generator / deserializer pair.
// Default window/timeout values assume the production 50 MHz clock and 50 Hz pulse rate.
package pwm_pkg;

   localparam int SYS_FREQ_DEF   = 50000000;
   localparam int PULSE_FREQ_DEF = 50;
   localparam int PULSE_WINDOW   = SYS_FREQ_DEF / PULSE_FREQ_DEF;
   localparam int TIMEOUT        = 2 * PULSE_WINDOW;

   localparam int DUTY_PENDOWN = 200000;
   localparam int DUTY_PENUP   = 50000;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} pwm_state_e;

   function automatic int timeout_cycles(input int sys_freq, input int pulse_freq);
      return 2 * (sys_freq / pulse_freq);
   endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizes the asynchronous PWM pin and derives level/rise/fall strobes.
// Define PWM_GLITCH_FILTER_EN to require FILTER_LEN steady samples before the level changes.
module pwm_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pwm_in,
   output logic s,
   output logic rise,
   output logic fall
);
   import pwm_pkg::*;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lvl;
   logic                   s_prev_q;

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
   end

`ifdef PWM_GLITCH_FILTER_EN
   localparam int FILTER_LEN = 4;
   localparam int RUN_W      = $clog2(FILTER_LEN);

   logic             filt_q;
   logic [RUN_W-1:0] run_q;

   // run_q counts consecutive samples disagreeing with the filtered level
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q <= 1'b0;
         run_q  <= '0;
      end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
         if (run_q == RUN_W'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            run_q  <= '0;
         end else begin
            run_q <= run_q + 1'b1;
         end
      end else begin
         run_q <= '0;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk) begin
      if (reset) s_prev_q <= 1'b0;
      else       s_prev_q <= lvl;
   end

   assign s    = lvl;
   assign rise = lvl & ~s_prev_q;
   assign fall = ~lvl & s_prev_q;

endmodule

// File: rtl/pwm_deserializer.sv
// Measures high time and rise-to-rise period of an incoming PWM and decodes the pen state.
// Optional input glitch filter: PWM_GLITCH_FILTER_EN (implemented in pwm_in_sync).
module pwm_deserializer #(
   parameter int SYS_FREQ    = 50000000,
   parameter int PULSE_FREQ  = 50,
   parameter int THRESHOLD   = 125000,
   parameter int CNT_BITS    = 21,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pwm_in,
   output logic [CNT_BITS-1:0] high_cycles,
   output logic [CNT_BITS-1:0] period_cycles,
   output logic                meas_valid,
   output logic                timeout,
   output logic [31:0]         regOut
);
   import pwm_pkg::*;

   localparam logic [CNT_BITS-1:0] TMO = CNT_BITS'(timeout_cycles(SYS_FREQ, PULSE_FREQ));
   localparam logic [CNT_BITS-1:0] THR = CNT_BITS'(THRESHOLD);

   logic s, rise, fall;

   pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
   );

   pwm_state_e          state_q, state_d;
   logic [CNT_BITS-1:0] period_q, period_d, high_q, high_d;
   logic [CNT_BITS-1:0] high_cyc_q, high_cyc_d, period_cyc_q, period_cyc_d;
   logic                valid_q, valid_d, tmo_q, tmo_d;
   logic [31:0]         reg_q, reg_d;
   logic                tmo_hit;

   // A period that has run to TIMEOUT abandons the measurement, even on a coincident rise
   assign tmo_hit = (state_q != IDLE) && (period_q == TMO);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         period_q     <= '0;
         high_q       <= '0;
         high_cyc_q   <= '0;
         period_cyc_q <= '0;
         valid_q      <= 1'b0;
         tmo_q        <= 1'b0;
         reg_q        <= 32'd1;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         high_q       <= high_d;
         high_cyc_q   <= high_cyc_d;
         period_cyc_q <= period_cyc_d;
         valid_q      <= valid_d;
         tmo_q        <= tmo_d;
         reg_q        <= reg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise) state_d = HIGH;
         HIGH:    if (tmo_hit) state_d = IDLE; else if (fall) state_d = LOW;
         LOW:     if (tmo_hit) state_d = IDLE; else if (rise) state_d = HIGH;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      period_d     = period_q;
      high_d       = high_q;
      high_cyc_d   = high_cyc_q;
      period_cyc_d = period_cyc_q;
      valid_d      = 1'b0;
      tmo_d        = tmo_q;
      reg_d        = reg_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               period_d = CNT_BITS'(1);
               high_d   = CNT_BITS'(1);
            end
         end
         HIGH: begin
            if (tmo_hit) begin
               tmo_d = 1'b1;
            end else begin
               // s drops on the fall cycle, so that cycle counts toward the period only
               period_d = (period_q < TMO) ? period_q + 1'b1 : period_q;
               high_d   = (high_q < TMO) ? high_q + CNT_BITS'(s) : high_q;
            end
         end
         LOW: begin
            if (tmo_hit) begin
               tmo_d = 1'b1;
            end else if (rise) begin
               high_cyc_d   = high_q;
               period_cyc_d = period_q;
               reg_d        = (high_q >= THR) ? 32'd0 : 32'd1;
               valid_d      = 1'b1;
               tmo_d        = 1'b0;
               period_d     = CNT_BITS'(1);
               high_d       = CNT_BITS'(1);
            end else begin
               period_d = (period_q < TMO) ? period_q + 1'b1 : period_q;
            end
         end
         default: ;
      endcase
   end

   assign high_cycles   = high_cyc_q;
   assign period_cycles = period_cyc_q;
   assign meas_valid    = valid_q;
   assign timeout       = tmo_q;
   assign regOut        = reg_q;

endmodule

// File: tb/tb_pwm_deserializer.sv
// Scoreboard bench: the driver's edge-timing model predicts each measurement strobe,
// a negedge monitor pops and compares whenever meas_valid is seen.
module tb_pwm_deserializer;

   localparam int SYNC = 2;
   localparam int TMO  = 2000;
   localparam int THR  = 125;
   localparam int CNTB = 21;
`ifdef PWM_GLITCH_FILTER_EN
   localparam int FLEN = 4;
   localparam int LAT  = SYNC + 2;   // counted from the cycle the filtered level settles
`else
   localparam int LAT  = SYNC + 1;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            pwm_in;
   logic [CNTB-1:0] high_cycles, period_cycles;
   logic            meas_valid, timeout;
   logic [31:0]     regOut;

   pwm_deserializer #(
      .SYS_FREQ(50000), .PULSE_FREQ(50), .THRESHOLD(THR), .CNT_BITS(CNTB), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .reset(reset), .pwm_in(pwm_in),
      .high_cycles(high_cycles), .period_cycles(period_cycles),
      .meas_valid(meas_valid), .timeout(timeout), .regOut(regOut)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int hi; int per; int at;} exp_t;
   exp_t q[$];
   int   vec = 0, err = 0;

   // reference model: edge timestamps of the (optionally filtered) input level
   logic m_prev = 1'b0, m_armed = 1'b0;
   int   m_rise = 0, m_fall = 0;
   int   held_hi = 0, held_per = 0;
`ifdef PWM_GLITCH_FILTER_EN
   logic f_lev = 1'b0;
   int   f_run = 0;
`endif

   task automatic chk(input string nm, input int act, input int exp_v);
      vec++;
      if (act != exp_v) begin
         err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic model_reset();
      m_prev = 1'b0; m_armed = 1'b0;
`ifdef PWM_GLITCH_FILTER_EN
      f_lev = 1'b0; f_run = 0;
`endif
   endtask

   task automatic model_step(input logic lvl);
      logic l;
      l = lvl;
`ifdef PWM_GLITCH_FILTER_EN
      if (lvl != f_lev) begin
         f_run++;
         if (f_run == FLEN) begin f_lev = lvl; f_run = 0; end
      end else f_run = 0;
      l = f_lev;
`endif
      if (m_armed && (cyc - m_rise) >= TMO) m_armed = 1'b0;
      if (l && !m_prev) begin
         if (m_armed) begin
            q.push_back('{hi: m_fall - m_rise, per: cyc - m_rise, at: cyc + LAT});
            held_hi  = m_fall - m_rise;
            held_per = cyc - m_rise;
         end
         m_armed = 1'b1;
         m_rise  = cyc;
      end
      if (!l && m_prev) m_fall = cyc;
      m_prev = l;
   endtask

   task automatic drive(input logic lvl, input int n);
      repeat (n) begin
         @(negedge clk);
         pwm_in = lvl;
         model_step(lvl);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst high_cycles", int'(high_cycles), 0);
      chk("rst period_cycles", int'(period_cycles), 0);
      chk("rst meas_valid", int'(meas_valid), 0);
      chk("rst timeout", int'(timeout), 0);
      chk("rst regOut", int'(regOut), 1);
   endtask

   // A pin still high when reset releases looks like a fresh rise to the cleared
   // synchronizer; the model sees the same thing and lets that rise arm the FSM.
   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      model_step(pwm_in);
      chk_reset_vals();
   endtask

   task automatic chk_timeout_hold(input string nm);
      chk({nm, " timeout"}, int'(timeout), 1);
      chk({nm, " high held"}, int'(high_cycles), held_hi);
      chk({nm, " period held"}, int'(period_cycles), held_per);
      chk({nm, " regOut held"}, int'(regOut), (held_hi >= THR) ? 0 : 1);
   endtask

   logic mv_prev = 1'b0;
   always @(negedge clk) begin
      if (!reset && meas_valid) begin
         chk("strobe width", int'(mv_prev), 0);
         if (q.size() == 0) begin
            vec++; err++;
            $display("FAIL unexpected strobe: got high=%0d period=%0d, expected none (cycle %0d)",
                     high_cycles, period_cycles, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("high_cycles", int'(high_cycles), e.hi);
            chk("period_cycles", int'(period_cycles), e.per);
            chk("regOut", int'(regOut), (e.hi >= THR) ? 0 : 1);
            chk("timeout clr", int'(timeout), 0);
            chk("strobe cycle", cyc, e.at);
         end
      end
      mv_prev = meas_valid;
   end

   initial begin
      #(2000000);
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, lo;
      reset  = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_reset_vals();
      drive(0, 50);

      // pen-down, then pen-up
      repeat (4) begin drive(1, 200); drive(0, 800); end
      repeat (3) begin drive(1, 50);  drive(0, 950); end

      // stuck low after a 200/1000 measurement
      drive(1, 200); drive(0, 800);
      drive(1, 200); drive(0, 1790);
      chk("stuck-low early timeout", int'(timeout), 0);
      drive(0, 20);
      chk_timeout_hold("stuck-low");
      drive(0, 300);

      // recover, then stuck high
      repeat (2) begin drive(1, 200); drive(0, 800); end
      drive(1, 1990);
      chk("stuck-high early timeout", int'(timeout), 0);
      drive(1, 20);
      chk_timeout_hold("stuck-high");
      drive(0, 500);

      // reset in the middle of a high phase
      drive(1, 200); drive(0, 800); drive(1, 100);
      pulse_reset();
      drive(1, 100); drive(0, 800);
      repeat (2) begin drive(1, 200); drive(0, 800); end

      // short glitches inside a low phase
      drive(1, 200); drive(0, 300); drive(1, 1); drive(0, 200); drive(1, 3); drive(0, 296);
      repeat (2) begin drive(1, 200); drive(0, 800); end

      // random duty and period, all periods well inside TIMEOUT
      repeat (40) begin
         hi = $urandom_range(400, 5);
         lo = $urandom_range(1500, 5);
         drive(1, hi);
         drive(0, lo);
      end
      drive(1, 5); drive(0, 50);

      chk("queue drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
